// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding, FPU register map, command codes and byte helper
package fpu_seq_pkg;
  typedef enum logic [2:0] {IDLE, STROBE, GAP, GUARD, POLL, SETTLE, READ, DONE} state_t;
  localparam logic [1:0] FPU_ADDR_STATUS = 2'd0;
  localparam logic [1:0] FPU_ADDR_RESULT = 2'd1;
  localparam logic [1:0] FPU_ADDR_CMD    = 2'd2;
  localparam logic [1:0] FPU_ADDR_VAL    = 2'd3;
  localparam logic [7:0] FPU_CMD_SETY    = 8'd1;
  localparam logic [7:0] FPU_CMD_SETX    = 8'd2;
  localparam logic [7:0] FPU_CMD_DIV     = 8'd3;
  localparam logic [7:0] FPU_CMD_MUL     = 8'd4;
  // byte i of w, i = 0 is the most significant byte
  function automatic logic [7:0] byte_of(logic [31:0] w, logic [1:0] i);
    return 8'(w >> {~i, 3'b000});
  endfunction
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: 2-way round-robin arbiter
//   clk, rst_n : clock, async active-low reset
//   req_i      : request levels
//   en_i       : grant allowed this cycle
//   gnt_o      : one-hot grant (zero when not enabled or no request)
//   idx_o      : index of the winning requester
module fpu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);
  logic last_q;
  // on a tie the requester not granted last wins; a single request wins outright
  assign idx_o = (req_i == 2'b11) ? ~last_q : ~req_i[0];
  assign gnt_o = (en_i && |req_i) ? (idx_o ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (|gnt_o) last_q <= idx_o;
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: shares one byte-wide memory-mapped FPU between two requesters
//   clk, rst_n                      : clock, async active-low reset
//   req_i, reqN_op_i/_y_i/_x_i      : request levels, op (0 div, 1 mul), operands
//   done_o, result_o, err_o, busy_o : completion pulse, result, timeout flag, busy
//   fpu_sel/read/write_o, fpu_addr_o, fpu_wdata_o, fpu_rdata_i : FPU bus
//   FPU_SEQ_TIMEOUT_EN : enables the status-poll watchdog (TIMEOUT_CYCLES polls)
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic        req0_op_i,
  input  logic        req1_op_i,
  input  logic [31:0] req0_y_i,
  input  logic [31:0] req1_y_i,
  input  logic [31:0] req0_x_i,
  input  logic [31:0] req1_x_i,
  output logic [1:0]  done_o,
  output logic [31:0] result_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        fpu_sel_o,
  output logic        fpu_read_o,
  output logic        fpu_write_o,
  output logic [1:0]  fpu_addr_o,
  output logic [7:0]  fpu_wdata_o,
  input  logic [7:0]  fpu_rdata_i
);
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d, nxt_q, nxt_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] ridx_q, ridx_d;
  logic gnt_q, gnt_d, op_q, op_d, err_q, err_d;
  logic [31:0] y_q, y_d, x_q, x_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] gnt;
  logic gidx, cmd_acc;
  logic [7:0] wbyte;
  fpu_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_i),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gidx)
  );
  // write access sequence: 0 SETY, 1-4 Y bytes, 5 SETX, 6-9 X bytes, 10 op, 11 abort SETY
  assign cmd_acc = idx_q == 4'd0 || idx_q == 4'd5 || idx_q >= 4'd10;
  assign wbyte = (idx_q == 4'd0 || idx_q == 4'd11) ? FPU_CMD_SETY :
                 idx_q < 4'd5  ? byte_of(y_q, 2'(idx_q - 4'd1)) :
                 idx_q == 4'd5 ? FPU_CMD_SETX :
                 idx_q < 4'd10 ? byte_of(x_q, 2'(idx_q - 4'd6)) :
                 op_q ? FPU_CMD_MUL : FPU_CMD_DIV;
  always_comb begin
    state_d = state_q;
    nxt_d = nxt_q;
    idx_d = idx_q;
    ridx_d = ridx_q;
    gnt_d = gnt_q;
    op_d = op_q;
    y_d = y_q;
    x_d = x_q;
    result_d = result_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = STROBE;
        idx_d = 4'd0;
        ridx_d = 2'd0;
        gnt_d = gidx;
        op_d = gidx ? req1_op_i : req0_op_i;
        y_d = gidx ? req1_y_i : req0_y_i;
        x_d = gidx ? req1_x_i : req0_x_i;
        result_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
      end
      STROBE: begin
        state_d = GAP;
        nxt_d = idx_q == 4'd10 ? GUARD : idx_q == 4'd11 ? DONE : STROBE;
        idx_d = idx_q + 4'd1;
      end
      GAP: state_d = nxt_q;
      GUARD: state_d = POLL;
      POLL: if (!fpu_rdata_i[7]) begin
        state_d = SETTLE;
        idx_d = 4'd0;
      end else if (TO_EN && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = GAP;
        nxt_d = STROBE;
        idx_d = 4'd11;
        err_d = 1'b1;
      end else begin
        state_d = GAP;
        nxt_d = POLL;
        cnt_d = cnt_q + CW'(1);
      end
      SETTLE: begin
        state_d = idx_q[0] ? READ : SETTLE;
        idx_d = idx_q + 4'd1;
      end
      READ: begin
        state_d = GAP;
        nxt_d = &ridx_q ? DONE : READ;
        ridx_d = ridx_q + 2'd1;
        result_d = {result_q[23:0], fpu_rdata_i};
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      nxt_q <= IDLE;
      idx_q <= '0;
      ridx_q <= '0;
      gnt_q <= 1'b0;
      op_q <= 1'b0;
      y_q <= '0;
      x_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      idx_q <= idx_d;
      ridx_q <= ridx_d;
      gnt_q <= gnt_d;
      op_q <= op_d;
      y_q <= y_d;
      x_q <= x_d;
      result_q <= result_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  // bus outputs decode straight from state so an async reset clears them at once
  assign fpu_write_o = state_q == STROBE;
  assign fpu_read_o = state_q == POLL || state_q == READ;
  assign fpu_sel_o = fpu_read_o | fpu_write_o;
  assign fpu_addr_o = fpu_write_o ? (cmd_acc ? FPU_ADDR_CMD : FPU_ADDR_VAL) :
                      state_q == READ ? FPU_ADDR_RESULT : FPU_ADDR_STATUS;
  assign fpu_wdata_o = fpu_write_o ? wbyte : 8'd0;
  assign done_o = state_q == DONE ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign err_o = TO_EN & err_q & (state_q == DONE);
  assign busy_o = state_q != IDLE && state_q != DONE;
  assign result_o = result_q;
endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Bus-master sequencer that shares the single 8-bit memory-mapped FPU between two requesters. It accepts a divide or multiply request with two 32-bit IEEE-754 operands and arbitrates round-robin between requesters. It drives the FPU's command/value/status/result register protocol byte by byte and returns the 32-bit result with a done pulse. It sits between the compute clients and the FPU's `FPUsel/addr/read/write` port.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of status polls before abort; used only with the watchdog macro.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  2  per-requester request level; held until the matching `done` bit
- `req0_op`, `req1_op`  in  1  operation select, 0 = divide (Y/X), 1 = multiply (Y*X)
- `req0_y`, `req1_y`  in  32  Y operand (dividend / multiplicand)
- `req0_x`, `req1_x`  in  32  X operand
- `done`  out  2  one-cycle completion pulse, one bit per requester
- `result`  out  32  FPU result; valid in the `done` cycle and held until the next grant
- `err`  out  1  timeout flag, pulses with `done`
- `busy`  out  1  high from grant to `done`
- `fpu_sel`, `fpu_read`, `fpu_write`  out  1  FPU strobes; `fpu_sel = fpu_read | fpu_write`
- `fpu_addr`  out  2  0 status, 1 result, 2 command, 3 value
- `fpu_wdata`  out  8  byte written to the FPU
- `fpu_rdata`  in  8  byte read from the FPU; bit 7 of status = FPU busy

## Operation
- IDLE: if any `req` bit is high, the arbiter grants one requester. The sequencer latches op, Y and X into local registers, latches the grant index and sets `busy`.
- Arbitration: 2-way round-robin. The requester not granted last wins ties. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- Every bus access is 2 cycles: a STROBE cycle (one strobe high, addr/wdata valid), then a GAP cycle (all strobes low). The FPU advances its byte index on the strobe's falling edge and detects commands on the rising edge.
- WRITE phase issues 11 accesses in this order:
  - cmd 0x01
  - Y[31:24], Y[23:16], Y[15:8], Y[7:0] at addr 3
  - cmd 0x02
  - X bytes, most significant first
  - cmd 0x03 (divide) or 0x04 (multiply)
- GUARD: 1 idle cycle. The FPU busy bit is not valid until 1 cycle after the op command.
- POLL: status read, sampling `fpu_rdata[7]` in the strobe cycle.
  - If busy: GAP, then poll again.
  - If not busy: go to SETTLE.
- SETTLE: 2 idle cycles, for the FPU result register update and result-index clear.
- READ: 4 accesses at addr 1. The byte is captured in each strobe cycle, most significant first, into `result`.
- DONE: pulse `done[grant]`, clear `busy`, return to IDLE. A `req` still high in the cycle after DONE is a new request.
- Exactly 4 result reads are issued per operation. Fewer would desynchronise the FPU result index.

## Timing
- Reset values:
  - all strobes 0
  - `fpu_addr` 0, `fpu_wdata` 0
  - `done` 0, `err` 0, `busy` 0, `result` 0
  - state IDLE
- Grant cycle = cycle 0. First STROBE (cmd 0x01) is at cycle 1. Op command STROBE is at cycle 21. GUARD is cycle 23. First POLL STROBE is cycle 24.
- Latency: first not-busy sample at poll cycle P → first result STROBE at P+3 → `done` at P+11.
- Best case (not busy on first poll): `done` at cycle 35.
- Operands are sampled only at grant; `req*` operand changes afterwards are ignored.
- `rst_n` low mid-transaction: all outputs go to reset values immediately. The FPU is not reset.
  - The next transaction's leading cmd 0x01 aborts any in-flight FPU operation.
  - A stale result index is cleared by the FPU on the next completion.
- Simultaneous `req` bits during a transaction are held pending and are not lost.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A poll counter aborts after `TIMEOUT_CYCLES` busy polls.
  - The abort issues cmd 0x01 (one access), then DONE with `err` = 1 and `result` = 0.
- Not defined:
  - Polling is unbounded.
  - `err` is tied 0.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `fpu_seq_pkg` holds:
  - the state enum (IDLE, STROBE, GAP, GUARD, POLL, SETTLE, READ, DONE)
  - FPU address constants (`FPU_ADDR_STATUS` = 0, `FPU_ADDR_RESULT` = 1, `FPU_ADDR_CMD` = 2, `FPU_ADDR_VAL` = 3)
  - command codes (`FPU_CMD_SETY` = 1, `FPU_CMD_SETX` = 2, `FPU_CMD_DIV` = 3, `FPU_CMD_MUL` = 4)
- The 4-bit access index selects cmd/value bytes in the WRITE phase. A 2-bit index is used in READ.
- One sub-module: `fpu_rr_arbiter` (2-way round-robin; `req` in, one-hot grant plus index out, pointer updated on grant).

## Test plan
- req0 divide, Y=0x40C00000, X=0x40000000, real FPU → write bytes 01,40,C0,00,00,02,40,00,00,00,03; `result`=0x40400000; `done`=01.
- req1 multiply, Y=0x40400000, X=0x40000000 → last cmd byte 04; `result`=0x40C00000; `done`=10.
- Both `req` held high continuously after reset → grants alternate 0,1,0,1; no request starved.
- FPU stub reports busy for 40 polls → no addr-1 access before busy clears; first result STROBE exactly 3 cycles after the not-busy sample.
- `rst_n` pulsed during the Y[15:8] write → outputs 0 asynchronously; next request starts with cmd 0x01 and returns the correct result.
- `FPU_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, stub stuck busy → 16 polls, cmd 0x01 written, `done` and `err` pulse together, `result`=0.
